// File: rtl/align_shift_pipe.sv
// Pipelined mantissa-alignment right shifter with clamped shift amount and valid/ready flow control.
// Build option: define ALIGN_STICKY_EN to fold shifted-out bits into the result LSB as a sticky bit.
module align_shift_pipe #(
  parameter int MANT_W  = 23,
  parameter int SHAMT_W = 8,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SHAMT_W-1:0]  in_shamt,
  input  logic [MANT_W-1:0]   in_mant,
  input  logic                in_hidden,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W+3:0]   out_result,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int W   = MANT_W + 4;
  localparam int L   = $clog2(W + 1);
  localparam int LPS = (L + STAGES - 1) / STAGES;

  function automatic logic [L-1:0] clamp_amt(input logic [SHAMT_W-1:0] shamt);
    if (int'(shamt) >= W) return L'(W);
    return L'(shamt);
  endfunction

  function automatic logic [W-1:0] shift_levels(input logic [W-1:0] d, input logic [L-1:0] amt,
                                                input int lo, input int hi);
    logic [W-1:0] r;
    r = d;
    for (int j = 0; j < L; j++) begin
      if (j >= lo && j < hi && amt[j]) r = r >> (1 << j);
    end
    return r;
  endfunction

`ifdef ALIGN_STICKY_EN
  function automatic logic sticky_levels(input logic [W-1:0] d, input logic [L-1:0] amt,
                                         input int lo, input int hi);
    logic [W-1:0] r;
    logic         s;
    r = d;
    s = 1'b0;
    for (int j = 0; j < L; j++) begin
      if (j >= lo && j < hi && amt[j]) begin
        s = s | (|(r & ~({W{1'b1}} << (1 << j))));
        r = r >> (1 << j);
      end
    end
    return s;
  endfunction
`endif

  logic w_stall;
  logic w_en;

  // A full stall freezes every stage; bubbles are deliberately not squeezed out.
  assign w_stall  = out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = s * LPS;
    localparam int HI = ((s + 1) * LPS > L) ? L : (s + 1) * LPS;

    logic [W-1:0]     w_d;
    logic [L-1:0]     w_amt;
    logic [TAG_W-1:0] w_tag;
    logic             w_vld;
    logic [W-1:0]     r_data;
    logic [TAG_W-1:0] r_tag;
    logic             r_vld;
`ifdef ALIGN_STICKY_EN
    logic             w_stk;
    logic             r_stk;
`endif

    // ---- stage input select: operand port for stage 0, previous stage otherwise
    if (s == 0) begin : g_src
      assign w_d   = {in_hidden, in_mant, 3'b000};
      assign w_amt = clamp_amt(in_shamt);
      assign w_tag = in_tag;
      assign w_vld = in_valid;
`ifdef ALIGN_STICKY_EN
      assign w_stk = 1'b0;
`endif
    end else begin : g_src
      assign w_d   = g_stg[s-1].r_data;
      assign w_amt = g_stg[s-1].g_amt.r_amt;
      assign w_tag = g_stg[s-1].r_tag;
      assign w_vld = g_stg[s-1].r_vld;
`ifdef ALIGN_STICKY_EN
      assign w_stk = g_stg[s-1].r_stk;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
      end else if (w_en) begin
        r_vld <= w_vld;
      end
    end

    // ---- stage register boundary: output stage data is cleared on reset, inner stages are not
    if (s == STAGES - 1) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
          r_tag  <= '0;
`ifdef ALIGN_STICKY_EN
          r_stk  <= 1'b0;
`endif
        end else if (w_en) begin
          r_data <= shift_levels(w_d, w_amt, LO, HI);
          r_tag  <= w_tag;
`ifdef ALIGN_STICKY_EN
          r_stk  <= w_stk | sticky_levels(w_d, w_amt, LO, HI);
`endif
        end
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (w_en) begin
          r_data <= shift_levels(w_d, w_amt, LO, HI);
          r_tag  <= w_tag;
`ifdef ALIGN_STICKY_EN
          r_stk  <= w_stk | sticky_levels(w_d, w_amt, LO, HI);
`endif
        end
      end
    end

    // The remaining shift amount is only carried forward to stages that still need it.
    if (s < STAGES - 1) begin : g_amt
      logic [L-1:0] r_amt;
      always_ff @(posedge clk) begin
        if (w_en) r_amt <= w_amt;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_vld;
  assign out_tag   = g_stg[STAGES-1].r_tag;
`ifdef ALIGN_STICKY_EN
  assign out_result = {g_stg[STAGES-1].r_data[W-1:1],
                       g_stg[STAGES-1].r_data[0] | g_stg[STAGES-1].r_stk};
`else
  assign out_result = g_stg[STAGES-1].r_data;
`endif

endmodule

// File: tb/tb_align_shift_pipe.sv
// Directed bench for align_shift_pipe: values, clamping, streaming, stall and reset, plus
// latency on STAGES=1/2/4 instances sharing one stimulus.
module tb_align_shift_pipe;

  localparam int STAGES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_shamt = '0;
  logic [22:0] in_mant = '0;
  logic        in_hidden = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, in_ready1, in_ready4;
  logic        out_valid, out_valid1, out_valid4;
  logic [26:0] out_result, out_result1, out_result4;
  logic [3:0]  out_tag, out_tag1, out_tag4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  align_shift_pipe #(.MANT_W(23), .SHAMT_W(8), .STAGES(STAGES), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_shamt(in_shamt), .in_mant(in_mant), .in_hidden(in_hidden), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag));

  align_shift_pipe #(.MANT_W(23), .SHAMT_W(8), .STAGES(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_shamt(in_shamt), .in_mant(in_mant), .in_hidden(in_hidden), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .out_result(out_result1), .out_tag(out_tag1));

  align_shift_pipe #(.MANT_W(23), .SHAMT_W(8), .STAGES(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_shamt(in_shamt), .in_mant(in_mant), .in_hidden(in_hidden), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready), .out_result(out_result4), .out_tag(out_tag4));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input string name, input logic [7:0] sh, input logic [22:0] m,
                            input logic h, input logic [3:0] t, input logic [26:0] exp);
    int n;
    in_shamt = sh; in_mant = m; in_hidden = h; in_tag = t; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
    end else begin
      checks++;
      if (out_result !== exp) begin
        errors++;
        $display("FAIL %s result: got %h required %h", name, out_result, exp);
      end
      checks++;
      if (out_tag !== t) begin
        errors++;
        $display("FAIL %s tag: got %h required %h", name, out_tag, t);
      end
      checks++;
      if (n !== STAGES - 1) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, n + 1, STAGES);
      end
    end
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 27'h0 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%h required 0/0/0",
               out_valid, out_result, out_tag);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
  endtask

  task automatic test_latency();
    int l1, l2, l4;
    l1 = 0; l2 = 0; l4 = 0;
    in_shamt = 8'd0; in_mant = 23'h555555; in_hidden = 1'b1; in_tag = 4'h9; in_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      in_valid = 1'b0;
      if (out_valid1 && l1 == 0) begin
        l1 = c;
        checks++;
        if (out_result1 !== 27'h6AAAAA8) begin
          errors++;
          $display("FAIL lat1_result: got %h required 6aaaaa8", out_result1);
        end
      end
      if (out_valid && l2 == 0) begin
        l2 = c;
        checks++;
        if (out_result !== 27'h6AAAAA8) begin
          errors++;
          $display("FAIL lat2_result: got %h required 6aaaaa8", out_result);
        end
      end
      if (out_valid4 && l4 == 0) begin
        l4 = c;
        checks++;
        if (out_result4 !== 27'h6AAAAA8 || out_tag4 !== 4'h9) begin
          errors++;
          $display("FAIL lat4_result: got %h/%h required 6aaaaa8/9", out_result4, out_tag4);
        end
      end
    end
    checks++;
    if (l1 !== 1) begin errors++; $display("FAIL latency_s1: got %0d required 1", l1); end
    checks++;
    if (l2 !== 2) begin errors++; $display("FAIL latency_s2: got %0d required 2", l2); end
    checks++;
    if (l4 !== 4) begin errors++; $display("FAIL latency_s4: got %0d required 4", l4); end
    repeat (3) cyc();
  endtask

  task automatic test_shift();
    send_check("hid_shift1", 8'd1, 23'h000000, 1'b1, 4'h3, 27'h2000000);
`ifdef ALIGN_STICKY_EN
    send_check("sticky_shift5", 8'd5, 23'h000001, 1'b1, 4'h5, 27'h0200001);
`else
    send_check("trunc_shift5", 8'd5, 23'h000001, 1'b1, 4'h5, 27'h0200000);
`endif
    send_check("shift0", 8'd0, 23'h555555, 1'b1, 4'hA, 27'h6AAAAA8);
    send_check("shift26", 8'd26, 23'h000000, 1'b1, 4'h1, 27'h0000001);
    send_check("shift24", 8'd24, 23'h400000, 1'b1, 4'h2, 27'h0000006);
    send_check("shift3_denorm", 8'd3, 23'h7FFFFF, 1'b0, 4'h4, 27'h07FFFFF);
  endtask

  task automatic test_clamp();
`ifdef ALIGN_STICKY_EN
    send_check("clamp27", 8'd27, 23'h7FFFFF, 1'b1, 4'h6, 27'h0000001);
    send_check("clamp200", 8'd200, 23'h7FFFFF, 1'b1, 4'h7, 27'h0000001);
    send_check("clamp255", 8'd255, 23'h000000, 1'b1, 4'hB, 27'h0000001);
`else
    send_check("clamp27", 8'd27, 23'h7FFFFF, 1'b1, 4'h6, 27'h0000000);
    send_check("clamp200", 8'd200, 23'h7FFFFF, 1'b1, 4'h7, 27'h0000000);
    send_check("clamp255", 8'd255, 23'h000000, 1'b1, 4'hB, 27'h0000000);
`endif
    send_check("clamp_zero", 8'd200, 23'h000000, 1'b0, 4'h8, 27'h0000000);
  endtask

  task automatic test_back_to_back();
    int got, first, last;
    logic [26:0] exp;
    got = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 8 + STAGES + 3; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_shamt = 8'(c); in_mant = 23'h0; in_hidden = 1'b1; in_tag = 4'(c);
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (out_valid) begin
        exp = 27'h4000000 >> c;
        exp = 27'h4000000 >> got;
        checks++;
        if (out_result !== exp || out_tag !== 4'(got)) begin
          errors++;
          $display("FAIL b2b_item%0d: got %h/%h required %h/%h", got, out_result, out_tag,
                   exp, 4'(got));
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    checks++;
    if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d required 8", got); end
    checks++;
    if (last - first !== 7) begin
      errors++;
      $display("FAIL b2b_consecutive: span %0d required 7", last - first);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_shamt = 8'd2; in_mant = 23'h0; in_hidden = 1'b1; in_tag = 4'hA;
    cyc();
    in_shamt = 8'd4; in_tag = 4'hB;
    cyc();
    in_shamt = 8'd6; in_tag = 4'hC;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'hA || out_result !== 27'h1000000)
      begin
        errors++;
        $display("FAIL stall_hold%0d: got rdy=%b vld=%b tag=%h res=%h required 0/1/a/1000000",
                 k, in_ready, out_valid, out_tag, out_result);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'hB || out_result !== 27'h0400000) begin
      errors++;
      $display("FAIL stall_next_b: got vld=%b tag=%h res=%h required 1/b/0400000",
               out_valid, out_tag, out_result);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'hC || out_result !== 27'h0100000) begin
      errors++;
      $display("FAIL stall_next_c: got vld=%b tag=%h res=%h required 1/c/0100000",
               out_valid, out_tag, out_result);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_shamt = 8'd1; in_mant = 23'h123456; in_hidden = 1'b1; in_tag = 4'hE;
    cyc();
    in_tag = 4'hF;
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 27'h0 || out_tag !== 4'h0) begin
      errors++;
      $display("FAIL midflight_async: got vld=%b res=%h tag=%h required 0/0/0",
               out_valid, out_result, out_tag);
    end
    out_ready = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midflight_stale: got %0d stale results required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_shift();
    test_clamp();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
